regression_sample_loader: RTL and testbench

//  Write side of the regression sample memory. Accepts N (x,y) samples over a valid/ready stream and writes them to

---
 rtl/regression_sample_loader.sv | 113 +++++++++++
 tb/tb_regression_sample_loader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regression_sample_loader.sv
// Write side of the regression sample memory: loads N (x,y) samples from a valid/ready stream,
// then sequences the two-pass regression controller through start1/end1 and start2/end2.
module regression_sample_loader #(
  parameter int unsigned DataW    = 20,
  parameter int unsigned AddrW    = 8,
  parameter int unsigned BaseAddr = 106,
  parameter int unsigned LastAddr = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             go_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DataW-1:0] in_x_i,
  input  logic [DataW-1:0] in_y_i,
  output logic             mem_we_o,
  output logic [AddrW-1:0] mem_addr_o,
  output logic [DataW-1:0] mem_x_o,
  output logic [DataW-1:0] mem_y_o,
  output logic             start1_o,
  output logic             start2_o,
  input  logic             end1_i,
  input  logic             end2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [7:0]       sample_cnt_o
);

  localparam logic [AddrW-1:0] BaseA = AddrW'(BaseAddr);
  localparam logic [AddrW-1:0] LastA = AddrW'(LastAddr);

  typedef enum logic [2:0] {
    StIdle, StFill, StFlush, StKick1, StWait1, StKick2, StWait2, StDone
  } state_e;

  state_e           state_q, state_d;
  logic [AddrW-1:0] ptr_q, ptr_d;
  logic [7:0]       cnt_q, cnt_d;
  logic             we_q, we_d;
  logic [AddrW-1:0] addr_q, addr_d;
  logic [DataW-1:0] x_q, x_d;
  logic [DataW-1:0] y_q, y_d;
  logic             accept;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      ptr_q   <= BaseA;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign accept = (state_q == StFill) && in_valid_i;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    // Write port is a one-cycle registered copy of the accepted beat; addr/data hold otherwise.
    we_d    = accept;
    addr_d  = accept ? ptr_q  : addr_q;
    x_d     = accept ? in_x_i : x_q;
    y_d     = accept ? in_y_i : y_q;
    unique case (state_q)
      StIdle: begin
        if (go_i) begin
          state_d = StFill;
          ptr_d   = BaseA;
          cnt_d   = '0;
        end
      end
      StFill: begin
        if (accept) begin
          cnt_d = cnt_q + 8'd1;
          // Pointer parks on the last address so it never wraps within a run.
          if (ptr_q == LastA) state_d = StFlush;
          else                ptr_d   = ptr_q + 1'b1;
        end
      end
      StFlush: state_d = StKick1;
      StKick1: state_d = StWait1;
      StWait1: if (end1_i) state_d = StKick2;
      StKick2: state_d = StWait2;
      StWait2: if (end2_i) state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign in_ready_o   = (state_q == StFill);
  assign mem_we_o     = we_q;
  assign mem_addr_o   = addr_q;
  assign mem_x_o      = x_q;
  assign mem_y_o      = y_q;
  assign start1_o     = (state_q == StKick1);
  assign start2_o     = (state_q == StKick2);
  assign busy_o       = (state_q != StIdle);
  assign done_o       = (state_q == StDone);
  assign sample_cnt_o = cnt_q;

endmodule

// File: tb/tb_regression_sample_loader.sv
// Directed bench for regression_sample_loader: load/sequence runs, stray handshakes,
// held go, mid-run reset, with a monitor that captures writes into a shadow memory.
module tb_regression_sample_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        go_i, in_valid_i, end1_i, end2_i;
  logic [19:0] in_x_i, in_y_i;
  logic        in_ready_o, mem_we_o, start1_o, start2_o, busy_o, done_o;
  logic [7:0]  mem_addr_o, sample_cnt_o;
  logic [19:0] mem_x_o, mem_y_o;

  int n_cmp = 0;
  int n_err = 0;
  int exp_addr = 106;
  int wr_cnt = 0;
  logic [19:0] mem_x_m [256];
  logic [19:0] mem_y_m [256];

  regression_sample_loader dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .go_i        (go_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_x_i      (in_x_i),
    .in_y_i      (in_y_i),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_x_o     (mem_x_o),
    .mem_y_o     (mem_y_o),
    .start1_o    (start1_o),
    .start2_o    (start2_o),
    .end1_i      (end1_i),
    .end2_i      (end2_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .sample_cnt_o(sample_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Every write must land on the next contiguous address; data goes to the shadow memory.
  always @(negedge clk_i) begin
    if (rst_ni && mem_we_o) begin
      check_eq("wr_addr", 32'(mem_addr_o), 32'(exp_addr));
      mem_x_m[mem_addr_o] = mem_x_o;
      mem_y_m[mem_addr_o] = mem_y_o;
      exp_addr++;
      wr_cnt++;
    end
  end

  // Entered right after the edge of the final accept (loader is in FLUSH).
  task automatic run_tail(input bit stray_end2, input bit late_valid);
    check_eq("flush_we", 32'(mem_we_o), 32'd1);
    check_eq("flush_addr", 32'(mem_addr_o), 32'd255);
    check_eq("flush_start1", 32'(start1_o), 32'd0);
    check_eq("flush_ready", 32'(in_ready_o), 32'd0);
    check_eq("flush_cnt", 32'(sample_cnt_o), 32'd150);
    tick();
    check_eq("kick1_start1", 32'(start1_o), 32'd1);
    check_eq("kick1_we", 32'(mem_we_o), 32'd0);
    tick();
    check_eq("wait1_start1", 32'(start1_o), 32'd0);
    check_eq("wait1_busy", 32'(busy_o), 32'd1);
    if (stray_end2) begin
      end2_i = 1'b1;
      tick();
      end2_i = 1'b0;
      check_eq("stray_end2_start2", 32'(start2_o), 32'd0);
      check_eq("stray_end2_done", 32'(done_o), 32'd0);
      tick();
      check_eq("wait1_hold", 32'(start2_o), 32'd0);
    end
    end1_i = 1'b1;
    tick();
    end1_i = 1'b0;
    check_eq("kick2_start2", 32'(start2_o), 32'd1);
    tick();
    check_eq("wait2_start2", 32'(start2_o), 32'd0);
    if (late_valid) begin
      in_valid_i = 1'b1;
      check_eq("wait2_ready", 32'(in_ready_o), 32'd0);
      tick();
      check_eq("wait2_we", 32'(mem_we_o), 32'd0);
      in_valid_i = 1'b0;
    end
    end2_i = 1'b1;
    tick();
    end2_i = 1'b0;
    check_eq("done_pulse", 32'(done_o), 32'd1);
    tick();
    check_eq("done_low", 32'(done_o), 32'd0);
    check_eq("idle_busy", 32'(busy_o), 32'd0);
    check_eq("idle_cnt", 32'(sample_cnt_o), 32'd150);
    check_eq("run_writes", 32'(wr_cnt), 32'd150);
  endtask

  initial begin
    int acc;
    int k;
    bit v;
    rst_ni = 1'b0; go_i = 1'b0; in_valid_i = 1'b0; end1_i = 1'b0; end2_i = 1'b0;
    in_x_i = '0; in_y_i = '0;
    #3;
    check_eq("rst_ready", 32'(in_ready_o), 32'd0);
    check_eq("rst_we", 32'(mem_we_o), 32'd0);
    check_eq("rst_addr", 32'(mem_addr_o), 32'd0);
    check_eq("rst_x", 32'(mem_x_o), 32'd0);
    check_eq("rst_busy", 32'(busy_o), 32'd0);
    check_eq("rst_cnt", 32'(sample_cnt_o), 32'd0);
    check_eq("rst_start", 32'({start1_o, start2_o, done_o}), 32'd0);
    #10 rst_ni = 1'b1;
    tick();

    // Run 1: back-to-back stream, x=i, y=2i.
    go_i = 1'b1;
    tick();
    go_i = 1'b0;
    check_eq("fill_ready", 32'(in_ready_o), 32'd1);
    check_eq("fill_cnt0", 32'(sample_cnt_o), 32'd0);
    for (int i = 0; i < 150; i++) begin
      in_valid_i = 1'b1;
      in_x_i = 20'(i);
      in_y_i = 20'(2 * i);
      tick();
      check_eq("b2b_we", 32'(mem_we_o), 32'd1);
    end
    in_valid_i = 1'b0;
    run_tail(1'b0, 1'b0);
    check_eq("r1_x106", 32'(mem_x_m[106]), 32'd0);
    check_eq("r1_x200", 32'(mem_x_m[200]), 32'd94);
    check_eq("r1_y255", 32'(mem_y_m[255]), 32'd298);

    // Run 2: gapped stream with go held high, stray end1 in FILL, stray end2 in WAIT1,
    // in_valid asserted in WAIT2.
    exp_addr = 106;
    wr_cnt = 0;
    go_i = 1'b1;
    tick();
    check_eq("r2_cnt0", 32'(sample_cnt_o), 32'd0);
    acc = 0;
    k = 0;
    while (acc < 150 && k < 2000) begin
      v = (k % 3) != 1;
      in_valid_i = v;
      in_x_i = 20'(1000 + acc);
      in_y_i = 20'(7 * acc);
      end1_i = (k == 5);
      tick();
      end1_i = 1'b0;
      check_eq("gap_we", 32'(mem_we_o), 32'(v));
      if (v) acc++;
      k++;
    end
    in_valid_i = 1'b0;
    check_eq("gap_accepts", 32'(acc), 32'd150);
    run_tail(1'b1, 1'b1);
    check_eq("r2_x106", 32'(mem_x_m[106]), 32'd1000);
    check_eq("r2_x180", 32'(mem_x_m[180]), 32'd1074);
    check_eq("r2_y255", 32'(mem_y_m[255]), 32'd1043);

    // go still high: re-arm, then reset after 40 accepts.
    tick();
    go_i = 1'b0;
    check_eq("rearm_busy", 32'(busy_o), 32'd1);
    check_eq("rearm_cnt", 32'(sample_cnt_o), 32'd0);
    exp_addr = 106;
    wr_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      in_valid_i = 1'b1;
      in_x_i = 20'(i);
      in_y_i = 20'(i);
      tick();
    end
    check_eq("pre_rst_we", 32'(mem_we_o), 32'd1);
    check_eq("pre_rst_cnt", 32'(sample_cnt_o), 32'd40);
    #2 rst_ni = 1'b0;
    #1;
    check_eq("arst_we", 32'(mem_we_o), 32'd0);
    check_eq("arst_ready", 32'(in_ready_o), 32'd0);
    check_eq("arst_busy", 32'(busy_o), 32'd0);
    check_eq("arst_cnt", 32'(sample_cnt_o), 32'd0);
    check_eq("arst_addr", 32'(mem_addr_o), 32'd0);
    in_valid_i = 1'b0;
    #2 rst_ni = 1'b1;
    tick();
    check_eq("post_rst_idle", 32'(busy_o), 32'd0);
    exp_addr = 106;
    wr_cnt = 0;
    go_i = 1'b1;
    tick();
    go_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid_i = 1'b1;
      in_x_i = 20'(500 + i);
      in_y_i = 20'(i);
      tick();
      check_eq("fresh_addr", 32'(mem_addr_o), 32'(106 + i));
    end
    in_valid_i = 1'b0;
    tick();
    check_eq("fresh_writes", 32'(wr_cnt), 32'd3);
    check_eq("fresh_x106", 32'(mem_x_m[106]), 32'd500);
    check_eq("fresh_cnt", 32'(sample_cnt_o), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
